dct_rle_encoder: RTL and testbench

- Downstream neighbour of the per-coefficient DCT datapath in the DCT+RLE compression chain.
- Accepts one signed 19-bit DCT coefficient per valid handshake and quantizes it by arithmetic scaling with saturation.
- Run-length encodes zero coefficients into (run, value) tokens, with zero-run-limit (ZRL) and end-of-block (EOB) markers.
- Tokens are buffered in a small first-word-fall-through FIFO behind a valid/ready output, so the DCT side is backpressured cleanly.

---
 rtl/dct_rle_encoder_pkg.sv | 43 ++++
 rtl/dct_rle_encoder_if.sv | 26 ++
 rtl/dct_rle_encoder_token_fifo.sv | 53 +++++
 rtl/dct_rle_encoder.sv | 102 ++++++++++
 tb/tb_dct_rle_encoder.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_rle_encoder_pkg.sv
// Shared definitions for the DCT run-length encoder: field widths, token
// layout, special token encodings and the quantizer.
package dct_rle_encoder_pkg;

    localparam int COEF_W = 19;
    localparam int VAL_W  = 8;
    localparam int RUN_W  = 4;
    localparam int TOK_W  = RUN_W + VAL_W + 1;

    // Token bit layout, LSB first: eob, val, run
    localparam int EOB_BIT = 0;
    localparam int VAL_LSB = 1;
    localparam int RUN_LSB = VAL_W + 1;

    localparam logic [RUN_W-1:0] ZRL_RUN = RUN_W'((1 << RUN_W) - 1);

    typedef struct packed {
        logic [RUN_W-1:0]        run;
        logic signed [VAL_W-1:0] val;
        logic                    eob;
    } tok_t;

    localparam tok_t EOB_TOK = '{run: '0, val: '0, eob: 1'b1};

    localparam logic [COEF_W-1:0] POS_LIM = COEF_W'((1 << (VAL_W - 1)) - 1);
    localparam logic [COEF_W-1:0] NEG_LIM = COEF_W'(1 << (VAL_W - 1));

    // Sign-magnitude shift so rounding is toward zero, then saturate.
    function automatic logic signed [VAL_W-1:0] quantize(
        input logic signed [COEF_W-1:0] x,
        input int                       shift
    );
        logic [COEF_W-1:0] mag;
        logic [COEF_W-1:0] sh;
        mag = x[COEF_W-1] ? unsigned'(-x) : unsigned'(x);
        sh  = mag >> shift;
        if (!x[COEF_W-1])
            quantize = (sh > POS_LIM) ? POS_LIM[VAL_W-1:0] : sh[VAL_W-1:0];
        else
            quantize = (sh > NEG_LIM) ? NEG_LIM[VAL_W-1:0] : -sh[VAL_W-1:0];
    endfunction

endpackage

// File: rtl/dct_rle_encoder_if.sv
// Coefficient input and token output handshakes of the RLE encoder.
interface dct_rle_encoder_if;
    import dct_rle_encoder_pkg::*;

    logic                     coef_valid;
    logic                     coef_ready;
    logic signed [COEF_W-1:0] coef_in;
    logic                     coef_last;
    logic                     tok_valid;
    logic                     tok_ready;
    logic [RUN_W-1:0]         tok_run;
    logic signed [VAL_W-1:0]  tok_val;
    logic                     tok_eob;

    // Producer of coefficients / consumer of tokens
    modport master (
        output coef_valid, coef_in, coef_last, tok_ready,
        input  coef_ready, tok_valid, tok_run, tok_val, tok_eob
    );

    // The encoder itself
    modport slave (
        input  coef_valid, coef_in, coef_last, tok_ready,
        output coef_ready, tok_valid, tok_run, tok_val, tok_eob
    );
endinterface

// File: rtl/dct_rle_encoder_token_fifo.sv
// First-word-fall-through FIFO with a 2-wide write port and 1-wide read.
// When both write enables are set, din0 lands ahead of din1.
module token_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en0,
    input  logic                   wr_en1,
    input  logic [WIDTH-1:0]       din0,
    input  logic [WIDTH-1:0]       din1,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr_inc;
    logic [1:0]       n_wr;
    logic             do_rd;
    logic [WIDTH-1:0] first;

    assign n_wr       = {1'b0, wr_en0} + {1'b0, wr_en1};
    assign do_rd      = rd_en && !empty;
    assign first      = wr_en0 ? din0 : din1;
    assign wr_ptr_inc = wr_ptr + AW'(1);
    assign empty      = (count == '0);
    assign dout       = mem[rd_ptr];

    // Storage: the first (or only) token at wr_ptr, a second one right after
    always_ff @(posedge clk) begin
        if (wr_en0 || wr_en1) mem[wr_ptr] <= first;
        if (wr_en0 && wr_en1) mem[wr_ptr_inc] <= din1;
    end

    // Pointers wrap naturally at DEPTH; count tracks simultaneous push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_wr);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + (AW+1)'(n_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/dct_rle_encoder.sv
// Quantizes DCT coefficients and run-length encodes them into (run, value)
// tokens with ZRL and EOB markers, buffered behind a valid/ready output.
module dct_rle_encoder
    import dct_rle_encoder_pkg::*;
#(
    parameter int QSHIFT     = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    dct_rle_encoder_if.slave   bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                    accept;
    logic                    s1_valid;
    logic signed [VAL_W-1:0] s1_q;
    logic                    s1_last;
    logic [RUN_W-1:0]        zero_run;
    logic [RUN_W-1:0]        zero_run_nxt;
    logic                    main_push;
    tok_t                    main_tok;
    logic                    wr_en0;
    logic                    wr_en1;
    tok_t                    din0;
    tok_t                    din1;
    tok_t                    fifo_dout;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;

    // Room for two tokens from stage 1 plus two from the incoming coefficient
    assign bus.coef_ready = (fifo_count <= CNT_W'(FIFO_DEPTH - 4));
    assign accept         = bus.coef_valid && bus.coef_ready;

    // Stage 1: quantize the accepted coefficient
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_q    <= quantize(bus.coef_in, QSHIFT);
                s1_last <= bus.coef_last;
            end
        end
    end

    // Stage 2: run-length rules; EOB always follows the value/ZRL token
    always_comb begin
        zero_run_nxt = zero_run;
        main_push    = 1'b0;
        main_tok     = '0;
        if (s1_valid) begin
            if (s1_q != '0) begin
                main_push    = 1'b1;
                main_tok     = '{run: zero_run, val: s1_q, eob: 1'b0};
                zero_run_nxt = '0;
            end else if (zero_run == ZRL_RUN) begin
                main_push    = 1'b1;
                main_tok     = '{run: ZRL_RUN, val: '0, eob: 1'b0};
                zero_run_nxt = '0;
            end else begin
                zero_run_nxt = zero_run + RUN_W'(1);
            end
            if (s1_last) zero_run_nxt = '0;
        end
        wr_en0 = main_push || (s1_valid && s1_last);
        wr_en1 = main_push && s1_valid && s1_last;
        din0   = main_push ? main_tok : EOB_TOK;
        din1   = EOB_TOK;
    end

    // Zero-run counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) zero_run <= '0;
        else        zero_run <= zero_run_nxt;
    end

    token_fifo #(
        .WIDTH (TOK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en0 (wr_en0),
        .wr_en1 (wr_en1),
        .din0   (din0),
        .din1   (din1),
        .rd_en  (bus.tok_ready),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Token fields read as zero while nothing is buffered
    assign bus.tok_valid = !fifo_empty;
    assign bus.tok_run   = fifo_empty ? '0 : fifo_dout.run;
    assign bus.tok_val   = fifo_empty ? '0 : fifo_dout.val;
    assign bus.tok_eob   = fifo_empty ? 1'b0 : fifo_dout.eob;
endmodule

// File: tb/tb_dct_rle_encoder.sv
// Bench for dct_rle_encoder: directed sequences, a table of single-coefficient
// blocks, and a random block stream against a block-level reference model.
module tb_dct_rle_encoder;
    import dct_rle_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dct_rle_encoder_if bus();

    dct_rle_encoder #(.QSHIFT(6), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   ready_mode = 1;  // 0 low, 1 high, 2 random
    tok_t rcv_q[$];
    tok_t exp_q[$];

    typedef struct {
        int   coef;
        int   ntok;
        tok_t t0;
        tok_t t1;
    } vec_t;
    vec_t vecs[11];

    function automatic tok_t mk(input int r, input int v, input bit e);
        tok_t t;
        t.run = r[RUN_W-1:0];
        t.val = v[VAL_W-1:0];
        t.eob = e;
        return t;
    endfunction

    // Reference: quantize by truncating division, then count zeros per block
    function automatic void model_block(input int blk[$]);
        int zeros = 0;
        int q;
        foreach (blk[i]) begin
            q = blk[i] / 64;
            if (q > 127)  q = 127;
            if (q < -128) q = -128;
            if (q == 0) begin
                zeros++;
                if (zeros == 16) begin
                    exp_q.push_back(mk(15, 0, 0));
                    zeros = 0;
                end
            end else begin
                exp_q.push_back(mk(zeros, q, 0));
                zeros = 0;
            end
        end
        exp_q.push_back(mk(0, 0, 1));
    endfunction

    always @(posedge clk) cyc++;

    // Consumer ready pattern
    always begin
        case (ready_mode)
            0:       bus.tok_ready = 1'b0;
            1:       bus.tok_ready = 1'b1;
            default: bus.tok_ready = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        #1;
    end

    // Token monitor and occupancy bound
    always @(negedge clk) begin
        if (rst_n && bus.tok_valid && bus.tok_ready)
            rcv_q.push_back(mk(int'(bus.tok_run), int'(bus.tok_val), bus.tok_eob));
        if (rst_n) begin
            n_checks++;
            if (dut.fifo_count > 8) begin
                n_fail++;
                $display("FAIL fifo_bound: count=%0d limit=8", dut.fifo_count);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_tok(input string name, input tok_t exp);
        int   w = 0;
        tok_t t;
        while (rcv_q.size() == 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (rcv_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no token, expected run=%0d val=%0d eob=%0d",
                     name, exp.run, $signed(exp.val), exp.eob);
        end else begin
            t = rcv_q.pop_front();
            if (t !== exp) begin
                n_fail++;
                $display("FAIL %s: got run=%0d val=%0d eob=%0d expected run=%0d val=%0d eob=%0d",
                         name, t.run, $signed(t.val), t.eob, exp.run, $signed(exp.val), exp.eob);
            end
        end
    endtask

    // Present one coefficient and return just after the edge that accepts it
    task automatic send(input int c, input bit last);
        int guard = 0;
        bus.coef_valid = 1'b1;
        bus.coef_in    = COEF_W'(c);
        bus.coef_last  = last;
        while (!bus.coef_ready && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: coef_ready=0 expected 1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        bus.coef_valid = 1'b0;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_quiet(input string name);
        repeat (5) @(negedge clk);
        check(name, rcv_q.size(), 0);
        rcv_q.delete();
    endtask

    initial begin
        int t0;
        int nacc;
        int alt;
        bit acc;
        int blk[$];
        int w;

        vecs[0]  = '{262143,  2, mk(0, 127, 0),  mk(0, 0, 1)};
        vecs[1]  = '{-262144, 2, mk(0, -128, 0), mk(0, 0, 1)};
        vecs[2]  = '{-63,     1, mk(0, 0, 1),    mk(0, 0, 0)};
        vecs[3]  = '{-64,     2, mk(0, -1, 0),   mk(0, 0, 1)};
        vecs[4]  = '{63,      1, mk(0, 0, 1),    mk(0, 0, 0)};
        vecs[5]  = '{64,      2, mk(0, 1, 0),    mk(0, 0, 1)};
        vecs[6]  = '{8191,    2, mk(0, 127, 0),  mk(0, 0, 1)};
        vecs[7]  = '{8192,    2, mk(0, 127, 0),  mk(0, 0, 1)};
        vecs[8]  = '{-8191,   2, mk(0, -127, 0), mk(0, 0, 1)};
        vecs[9]  = '{-8192,   2, mk(0, -128, 0), mk(0, 0, 1)};
        vecs[10] = '{-8256,   2, mk(0, -128, 0), mk(0, 0, 1)};

        bus.coef_valid = 1'b0;
        bus.coef_in    = '0;
        bus.coef_last  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tok_valid", int'(bus.tok_valid), 0);
        check("rst_tok_run",   int'(bus.tok_run), 0);
        check("rst_tok_val",   int'(bus.tok_val), 0);
        check("rst_tok_eob",   int'(bus.tok_eob), 0);
        align();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_coef_ready", int'(bus.coef_ready), 1);
        align();

        // Basic block with 2-cycle latency
        send(128, 0);
        check("lat_after_accept", int'(bus.tok_valid), 0);
        send(0, 0);
        check("lat_after_2_edges", int'(bus.tok_valid), 1);
        send(0, 0);
        send(-192, 0);
        repeat (3) send(0, 0);
        send(0, 1);
        expect_tok("blk1_t0", mk(0, 2, 0));
        expect_tok("blk1_t1", mk(2, -3, 0));
        expect_tok("blk1_eob", mk(0, 0, 1));
        expect_quiet("blk1_extra");

        // ZRL after 16 zeros, no stall
        align();
        t0 = cyc;
        repeat (20) send(0, 0);
        send(64, 1);
        check("zrl_no_stall_cycles", cyc - t0, 21);
        expect_tok("zrl_t0", mk(15, 0, 0));
        expect_tok("zrl_t1", mk(4, 1, 0));
        expect_tok("zrl_eob", mk(0, 0, 1));
        expect_quiet("zrl_extra");

        // Saturation / rounding table
        for (int i = 0; i < 11; i++) begin
            align();
            send(vecs[i].coef, 1);
            expect_tok($sformatf("vec%0d_tok0", i), vecs[i].t0);
            if (vecs[i].ntok == 2) expect_tok($sformatf("vec%0d_tok1", i), vecs[i].t1);
        end
        expect_quiet("vec_extra");

        // Backpressure with alternating 64/0 and coef_valid held
        ready_mode = 0;
        align();
        align();
        nacc = 0;
        alt  = 0;
        bus.coef_valid = 1'b1;
        bus.coef_last  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.coef_in = (alt != 0) ? COEF_W'(0) : COEF_W'(64);
            acc = bus.coef_ready;
            align();
            if (acc) begin
                nacc++;
                alt ^= 1;
            end
        end
        bus.coef_valid = 1'b0;
        check("bp_accepts", nacc, 10);
        check("bp_ready_low", int'(bus.coef_ready), 0);
        check("bp_fifo_count", int'(dut.fifo_count), 5);
        ready_mode = 1;
        send(0, 1);
        blk = {64, 0, 64, 0, 64, 0, 64, 0, 64, 0, 0};
        exp_q.delete();
        model_block(blk);
        while (exp_q.size() > 0) expect_tok("bp_order", exp_q.pop_front());
        expect_quiet("bp_extra");

        // Reset mid-block with a token buffered
        ready_mode = 0;
        align();
        align();
        send(64, 0);
        repeat (3) send(0, 0);
        align();
        align();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tok_valid", int'(bus.tok_valid), 0);
        check("mid_rst_tok_run",   int'(bus.tok_run), 0);
        check("mid_rst_tok_val",   int'(bus.tok_val), 0);
        check("mid_rst_tok_eob",   int'(bus.tok_eob), 0);
        check("mid_rst_count",     int'(dut.fifo_count), 0);
        align();
        rst_n = 1'b1;
        check("mid_rst_coef_ready", int'(bus.coef_ready), 1);
        rcv_q.delete();
        ready_mode = 1;
        align();
        send(64, 1);
        expect_tok("post_rst_t0", mk(0, 1, 0));
        expect_tok("post_rst_eob", mk(0, 0, 1));
        expect_quiet("post_rst_extra");

        // Random block stream, random consumer
        ready_mode = 2;
        exp_q.delete();
        rcv_q.delete();
        for (int b = 0; b < 1000; b++) begin
            int len;
            int kind;
            blk.delete();
            kind = int'($urandom_range(0, 3));
            len  = (kind == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(1, 16));
            for (int i = 0; i < len; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (kind == 0 && r < 8)  blk.push_back(0);
                else if (r < 5)          blk.push_back(0);
                else if (r < 7)          blk.push_back(int'($urandom_range(0, 400)) - 200);
                else if (r < 9)          blk.push_back(int'($urandom_range(0, 40000)) - 20000);
                else                     blk.push_back(int'($urandom_range(0, 524287)) - 262144);
            end
            model_block(blk);
            foreach (blk[i]) send(blk[i], i == len - 1);
        end
        w = 0;
        while (rcv_q.size() < exp_q.size() && w < 20000) begin
            @(negedge clk);
            w++;
        end
        repeat (10) @(negedge clk);
        check("rand_token_count", rcv_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            n_checks++;
            if (rcv_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_tok%0d: got run=%0d val=%0d eob=%0d expected run=%0d val=%0d eob=%0d",
                         i, rcv_q[i].run, $signed(rcv_q[i].val), rcv_q[i].eob,
                         exp_q[i].run, $signed(exp_q[i].val), exp_q[i].eob);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
